// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if
// Bundles the signals of N pipelined Wishbone B4 masters and the single shared
// slave port around wb_rr_arbiter.
//   m_cyc/m_stb/m_we  per-master cycle, strobe, write enable (N bits each)
//   m_adr/m_sel/m_dat_m  per-master address, byte selects, write data, packed
//                     with master i at [i*W +: W]
//   m_dat_s           read data back to the masters (N copies)
//   m_ack/m_err/m_stall  per-master responses
//   s_*               the shared slave port (request out, response in)
// Modport "master" is the arbiter's view: it masters the shared slave and
// serves the requesting masters. Modport "slave" is the surrounding system's
// view: the requesting masters plus the shared slave.
interface wb_rr_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32
);
    logic [N_MASTERS-1:0]        m_cyc;
    logic [N_MASTERS-1:0]        m_stb;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*AW-1:0]     m_adr;
    logic [N_MASTERS*DW/8-1:0]   m_sel;
    logic [N_MASTERS*DW-1:0]     m_dat_m;
    logic [N_MASTERS*DW-1:0]     m_dat_s;
    logic [N_MASTERS-1:0]        m_ack;
    logic [N_MASTERS-1:0]        m_err;
    logic [N_MASTERS-1:0]        m_stall;

    logic                        s_cyc;
    logic                        s_stb;
    logic                        s_we;
    logic [AW-1:0]               s_adr;
    logic [DW/8-1:0]             s_sel;
    logic [DW-1:0]               s_dat_m;
    logic [DW-1:0]               s_dat_s;
    logic                        s_ack;
    logic                        s_err;
    logic                        s_stall;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m,
        output m_dat_s, m_ack, m_err, m_stall,
        output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m,
        input  s_dat_s, s_ack, s_err, s_stall
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m,
        input  m_dat_s, m_ack, m_err, m_stall,
        input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m,
        output s_dat_s, s_ack, s_err, s_stall
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin arbiter sharing one pipelined Wishbone B4 slave among N_MASTERS
// masters. A master that wins keeps the slave for its whole cyc burst; the
// arbiter counts accepted-but-unanswered requests and stalls the owner once
// MAX_OUTST are in flight. ack/err go back to the owner only.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  wb_rr_arbiter_if.master: all master-side and slave-side bus signals
module wb_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_rr_arbiter_if.master      bus
);
    localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = DW / 8;
    localparam logic [3:0] MAX_Q = 4'(MAX_OUTST);
    localparam logic [OW-1:0] LAST_RST = OW'(N_MASTERS - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [3:0]    outst_q, outst_d;

    logic [OW-1:0] next_owner;
    logic          any_req;
    logic          owner_cyc;
    logic          full;
    logic          accept;
    logic          done;

    // Cyclic search for the first requester after the last granted master.
    // Walking from the farthest candidate down to the nearest lets the
    // nearest one overwrite, so the result is the first hit after last_q.
    always_comb begin
        logic [OW-1:0] cand;
        next_owner = last_q;
        any_req    = |bus.m_cyc;
        cand       = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            cand = OW'((int'(last_q) + k) % N_MASTERS);
            if (bus.m_cyc[cand]) begin
                next_owner = cand;
            end
        end
    end

    assign owner_cyc = bus.m_cyc[owner_q];
    assign full      = (outst_q == MAX_Q);
    assign accept    = bus.s_stb & ~bus.s_stall;
    assign done      = bus.s_ack | bus.s_err;

    // Slave read data is simply broadcast; only ack/err say who it is for.
    assign bus.m_dat_s = {N_MASTERS{bus.s_dat_s}};

    // Request path and response routing. Reset forces the idle view
    // immediately so nothing leaks to the slave while reset is held. The
    // strobe also depends on the owner's cyc so that a stb left high at
    // release never reaches the slave without a cycle around it, and
    // responses arriving once the owner has let go are dropped.
    always_comb begin
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.m_stall = '1;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        bus.s_we    = bus.m_we[owner_q];
        bus.s_adr   = bus.m_adr[owner_q*AW +: AW];
        bus.s_sel   = bus.m_sel[owner_q*SW +: SW];
        bus.s_dat_m = bus.m_dat_m[owner_q*DW +: DW];
        if (!rst && state_q == OWNED) begin
            bus.s_cyc            = owner_cyc;
            bus.s_stb            = owner_cyc & bus.m_stb[owner_q] & ~full;
            bus.m_stall[owner_q] = bus.s_stall | full;
            if (owner_cyc) begin
                bus.m_ack[owner_q] = bus.s_ack;
                bus.m_err[owner_q] = bus.s_err;
            end
        end
    end

    // Next-state logic: grant on any request in IDLE, hold the grant until
    // the owner drops cyc, and track outstanding requests while owned.
    // last follows the new owner so a releasing master ends up at the back
    // of the rotation.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        outst_d = outst_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = next_owner;
                    last_d  = next_owner;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    outst_d = '0;
                end else if (accept && !done) begin
                    outst_d = outst_q + 4'd1;
                end else if (done && !accept && outst_q != '0) begin
                    outst_d = outst_q - 4'd1;
                end
            end
        endcase
    end

    // State register with synchronous reset; master 0 wins first because
    // last starts at the highest index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter with two masters and MAX_OUTST=4.
// Inputs change 1 ns after the rising edge; outputs are looked at 1 ns later,
// well away from the next edge.
module tb_wb_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    wb_rr_arbiter_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();

    wb_rr_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cyc   = '0;
        bus.m_stb   = '0;
        bus.m_we    = '0;
        bus.m_adr   = '0;
        bus.m_sel   = '0;
        bus.m_dat_m = '0;
        bus.s_dat_s = '0;
        bus.s_ack   = 1'b0;
        bus.s_err   = 1'b0;
        bus.s_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset dominates even with requests pending.
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.m_cyc = 2'b11;
        tick();
        tick();
        settle();
        n_cmp++; if (bus.s_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_s_cyc: got %b expected 0", bus.s_cyc); end
        n_cmp++; if (bus.s_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_s_stb: got %b expected 0", bus.s_stb); end
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL rst_m_stall: got %b expected 11", bus.m_stall); end
        n_cmp++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_m_ack: got %b expected 00", bus.m_ack); end
        n_cmp++; if (bus.m_err !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_m_err: got %b expected 00", bus.m_err); end
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_outst: got %0d expected 0", dut.outst_q); end
        bus.m_cyc = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    // Single master request: one-cycle latency, muxing, stall passthrough, ack routing.
    task automatic test_single_grant();
        do_reset();
        bus.m_adr   = {32'h0000_0200, 32'h0000_0100};
        bus.m_sel   = {4'hC, 4'h3};
        bus.m_dat_m = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        bus.m_we    = 2'b01;
        bus.s_dat_s = 32'h1234_5678;
        bus.m_cyc   = 2'b01;
        bus.m_stb   = 2'b01;
        settle();
        n_cmp++; if (bus.s_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_latency_s_stb: got %b expected 0", bus.s_stb); end
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t1_idle_stall: got %b expected 11", bus.m_stall); end
        n_cmp++; if (bus.m_dat_s !== 64'h1234_5678_1234_5678) begin n_fail++; $display("[TB] FAIL t1_dat_s_bcast: got %h expected 1234567812345678", bus.m_dat_s); end
        tick();
        n_cmp++; if (bus.s_cyc !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_s_cyc: got %b expected 1", bus.s_cyc); end
        n_cmp++; if (bus.s_stb !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_s_stb: got %b expected 1", bus.s_stb); end
        n_cmp++; if (bus.s_adr !== 32'h0000_0100) begin n_fail++; $display("[TB] FAIL t1_s_adr: got %h expected 00000100", bus.s_adr); end
        n_cmp++; if (bus.s_we !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_s_we: got %b expected 1", bus.s_we); end
        n_cmp++; if (bus.s_sel !== 4'h3) begin n_fail++; $display("[TB] FAIL t1_s_sel: got %h expected 3", bus.s_sel); end
        n_cmp++; if (bus.s_dat_m !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL t1_s_dat_m: got %h expected deadbeef", bus.s_dat_m); end
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t1_owned_stall: got %b expected 10", bus.m_stall); end
        bus.s_stall = 1'b1;
        settle();
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t1_stall_pass: got %b expected 11", bus.m_stall); end
        bus.s_stall = 1'b0;
        tick();
        bus.m_stb = 2'b00;
        bus.s_ack = 1'b1;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd1) begin n_fail++; $display("[TB] FAIL t1_outst_one: got %0d expected 1", dut.outst_q); end
        n_cmp++; if (bus.m_ack !== 2'b01) begin n_fail++; $display("[TB] FAIL t1_m_ack: got %b expected 01", bus.m_ack); end
        tick();
        bus.s_ack = 1'b0;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL t1_outst_zero: got %0d expected 0", dut.outst_q); end
        bus.m_cyc = 2'b00;
        settle();
        n_cmp++; if (bus.s_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_release_s_cyc: got %b expected 0", bus.s_cyc); end
        tick();
    endtask

    // Simultaneous requests resolve by rotation; releasing master goes last.
    task automatic test_rotation();
        do_reset();
        bus.m_cyc = 2'b11;
        tick();
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t2_first_owner0: got %b expected 10", bus.m_stall); end
        n_cmp++; if (bus.s_cyc !== 1'b1) begin n_fail++; $display("[TB] FAIL t2_s_cyc: got %b expected 1", bus.s_cyc); end
        bus.m_cyc = 2'b10;
        settle();
        n_cmp++; if (bus.s_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL t2_release0: got %b expected 0", bus.s_cyc); end
        tick();
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t2_idle_gap: got %b expected 11", bus.m_stall); end
        tick();
        n_cmp++; if (bus.m_stall !== 2'b01) begin n_fail++; $display("[TB] FAIL t2_owner1: got %b expected 01", bus.m_stall); end
        n_cmp++; if (bus.s_cyc !== 1'b1) begin n_fail++; $display("[TB] FAIL t2_owner1_cyc: got %b expected 1", bus.s_cyc); end
        bus.m_cyc = 2'b00;
        tick();
        bus.m_cyc = 2'b11;
        tick();
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t2_again_owner0: got %b expected 10", bus.m_stall); end
        bus.m_cyc = 2'b00;
        tick();
    endtask

    // Six strobes with no acks: four accepted, then full stalls the owner.
    task automatic test_outstanding_limit();
        int acc;
        do_reset();
        bus.m_cyc = 2'b01;
        bus.m_stb = 2'b01;
        tick();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.s_stb === 1'b1 && bus.s_stall === 1'b0) acc++;
            tick();
        end
        n_cmp++; if (acc !== 4) begin n_fail++; $display("[TB] FAIL t3_accepted: got %0d expected 4", acc); end
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t3_full_stall: got %b expected 11", bus.m_stall); end
        n_cmp++; if (bus.s_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_full_s_stb: got %b expected 0", bus.s_stb); end
        n_cmp++; if (dut.outst_q !== 4'd4) begin n_fail++; $display("[TB] FAIL t3_outst_full: got %0d expected 4", dut.outst_q); end
        bus.s_ack = 1'b1;
        settle();
        n_cmp++; if (bus.m_ack !== 2'b01) begin n_fail++; $display("[TB] FAIL t3_ack: got %b expected 01", bus.m_ack); end
        tick();
        bus.s_ack = 1'b0;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd3) begin n_fail++; $display("[TB] FAIL t3_outst_after_ack: got %0d expected 3", dut.outst_q); end
        n_cmp++; if (bus.s_stb !== 1'b1) begin n_fail++; $display("[TB] FAIL t3_reopen_s_stb: got %b expected 1", bus.s_stb); end
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t3_reopen_stall: got %b expected 10", bus.m_stall); end
        tick();
        n_cmp++; if (dut.outst_q !== 4'd4) begin n_fail++; $display("[TB] FAIL t3_outst_refull: got %0d expected 4", dut.outst_q); end
        n_cmp++; if (bus.s_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_refull_s_stb: got %b expected 0", bus.s_stb); end
        bus.m_stb = 2'b00;
        bus.m_cyc = 2'b00;
        tick();
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL t3_release_outst: got %0d expected 0", dut.outst_q); end
    endtask

    // Accept and ack together hold the count; ack/err both retire requests.
    task automatic test_same_cycle();
        int ack_cnt;
        int err_cnt;
        int other_cnt;
        do_reset();
        bus.m_cyc = 2'b01;
        bus.m_stb = 2'b01;
        tick();
        tick();
        tick();
        n_cmp++; if (dut.outst_q !== 4'd2) begin n_fail++; $display("[TB] FAIL t4_outst_two: got %0d expected 2", dut.outst_q); end
        bus.s_ack = 1'b1;
        settle();
        n_cmp++; if (bus.s_stb !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_both_s_stb: got %b expected 1", bus.s_stb); end
        tick();
        bus.s_ack = 1'b0;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd2) begin n_fail++; $display("[TB] FAIL t4_outst_hold: got %0d expected 2", dut.outst_q); end
        tick();
        tick();
        n_cmp++; if (dut.outst_q !== 4'd4) begin n_fail++; $display("[TB] FAIL t4_outst_four: got %0d expected 4", dut.outst_q); end
        bus.m_stb = 2'b00;
        ack_cnt   = 0;
        err_cnt   = 0;
        other_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            bus.s_ack = (i < 3);
            bus.s_err = (i == 3);
            settle();
            if (bus.m_ack[0] === 1'b1) ack_cnt++;
            if (bus.m_err[0] === 1'b1) err_cnt++;
            if (bus.m_ack[1] !== 1'b0 || bus.m_err[1] !== 1'b0) other_cnt++;
            tick();
        end
        bus.s_ack = 1'b0;
        bus.s_err = 1'b0;
        settle();
        n_cmp++; if (ack_cnt !== 3) begin n_fail++; $display("[TB] FAIL t4_ack_count: got %0d expected 3", ack_cnt); end
        n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("[TB] FAIL t4_err_count: got %0d expected 1", err_cnt); end
        n_cmp++; if (other_cnt !== 0) begin n_fail++; $display("[TB] FAIL t4_misrouted: got %0d expected 0", other_cnt); end
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL t4_outst_drained: got %0d expected 0", dut.outst_q); end
        bus.m_cyc = 2'b00;
        tick();
    endtask

    // Master 1 releases with requests in flight; late ack is dropped.
    task automatic test_release_late_ack();
        do_reset();
        bus.m_adr   = {32'h0000_0200, 32'h0000_0100};
        bus.m_sel   = {4'hC, 4'h3};
        bus.m_dat_m = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        bus.m_we    = 2'b10;
        bus.m_cyc   = 2'b10;
        bus.m_stb   = 2'b10;
        tick();
        n_cmp++; if (bus.s_adr !== 32'h0000_0200) begin n_fail++; $display("[TB] FAIL t5_s_adr: got %h expected 00000200", bus.s_adr); end
        n_cmp++; if (bus.s_we !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_s_we: got %b expected 1", bus.s_we); end
        n_cmp++; if (bus.s_sel !== 4'hC) begin n_fail++; $display("[TB] FAIL t5_s_sel: got %h expected c", bus.s_sel); end
        n_cmp++; if (bus.s_dat_m !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL t5_s_dat_m: got %h expected cafef00d", bus.s_dat_m); end
        n_cmp++; if (bus.m_stall !== 2'b01) begin n_fail++; $display("[TB] FAIL t5_owner1_stall: got %b expected 01", bus.m_stall); end
        tick();
        tick();
        bus.m_stb = 2'b00;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd2) begin n_fail++; $display("[TB] FAIL t5_outst_two: got %0d expected 2", dut.outst_q); end
        bus.m_cyc = 2'b01;
        settle();
        n_cmp++; if (bus.s_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_release_s_cyc: got %b expected 0", bus.s_cyc); end
        tick();
        bus.s_ack = 1'b1;
        settle();
        n_cmp++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL t5_late_ack: got %b expected 00", bus.m_ack); end
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t5_idle_stall: got %b expected 11", bus.m_stall); end
        tick();
        bus.s_ack = 1'b0;
        settle();
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t5_owner0_stall: got %b expected 10", bus.m_stall); end
        n_cmp++; if (bus.s_cyc !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_owner0_cyc: got %b expected 1", bus.s_cyc); end
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL t5_outst_clean: got %0d expected 0", dut.outst_q); end
        bus.m_cyc = 2'b00;
        tick();
    endtask

    // Reset in the middle of a burst clears everything; master 0 wins after.
    task automatic test_reset_mid_burst();
        do_reset();
        bus.m_cyc = 2'b10;
        bus.m_stb = 2'b10;
        tick();
        tick();
        tick();
        tick();
        bus.m_stb = 2'b00;
        settle();
        n_cmp++; if (dut.outst_q !== 4'd3) begin n_fail++; $display("[TB] FAIL t6_outst_three: got %0d expected 3", dut.outst_q); end
        rst = 1'b1;
        tick();
        bus.s_ack = 1'b1;
        settle();
        n_cmp++; if (bus.s_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_s_cyc: got %b expected 0", bus.s_cyc); end
        n_cmp++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("[TB] FAIL t6_m_stall: got %b expected 11", bus.m_stall); end
        n_cmp++; if (dut.outst_q !== 4'd0) begin n_fail++; $display("[TB] FAIL t6_outst: got %0d expected 0", dut.outst_q); end
        n_cmp++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("[TB] FAIL t6_ack_dropped: got %b expected 00", bus.m_ack); end
        bus.s_ack = 1'b0;
        rst       = 1'b0;
        bus.m_cyc = 2'b11;
        tick();
        n_cmp++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("[TB] FAIL t6_owner0_first: got %b expected 10", bus.m_stall); end
        bus.m_cyc = 2'b00;
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clear_inputs();
        $display("[TB] starting wb_rr_arbiter bench");
        test_reset();
        test_single_grant();
        test_rotation();
        test_outstanding_limit();
        test_same_cycle();
        test_release_late_ack();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
